// File: rtl/multiplexed_display_if.sv
// Front-panel display bus: view inputs from the parking controller and
// the registered active-low 7-segment / anode / colon drive back out.
interface multiplexed_display_if;
  logic       mode;
  logic [2:0] capacity;
  logic [1:0] empty_slot;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] seg;
  logic [3:0] anode;
  logic       colon;

  modport master (
    output mode, capacity, empty_slot, minutes, seconds,
    input  seg, anode, colon
  );

  modport slave (
    input  mode, capacity, empty_slot, minutes, seconds,
    output seg, anode, colon
  );
endinterface

// File: rtl/multiplexed_display.sv
// Four-digit time-multiplexed 7-segment driver (capacity/slot or MM:SS view).
// Optional macro COLON_BLINK_EN: colon blinks at 1 Hz in the time view.
module multiplexed_display (
  input  logic                  clk_500Hz,
  input  logic                  reset,
  multiplexed_display_if.slave  disp
);

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned DIG_W     = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned BLINK_W   = 8;
  localparam int unsigned BLINK_TERM = 249;

  localparam logic [DIG_W-1:0] DIG_BLANK = DIG_W'(10);
  localparam logic [DIG_W-1:0] DIG_DASH  = DIG_W'(11);

  // Digit value (0..9, blank, dash) to active-low gfedcba pattern
  function automatic logic [SEG_W-1:0] seg_of(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd11:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [IDX_W-1:0] scan_q, scan_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [3:0]       anode_q, anode_d;
  logic             colon_q, colon_d;
  logic             blink_c;

  logic [DIG_W-1:0] digit;
  logic [DIG_W-1:0] min_tens, min_ones, sec_tens, sec_ones;
  logic             min_ok, sec_ok;

`ifdef COLON_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  // 250-edge half period; flag low means colon lit
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_W'(BLINK_TERM)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_c = blink_q;
`else
  assign blink_c = 1'b0;
`endif

  // Pick the digit for the current scan slot and encode it
  always_comb begin
    min_ok   = (disp.minutes <= 6'd59);
    sec_ok   = (disp.seconds <= 6'd59);
    min_tens = DIG_W'(disp.minutes / 6'd10);
    min_ones = DIG_W'(disp.minutes % 6'd10);
    sec_tens = DIG_W'(disp.seconds / 6'd10);
    sec_ones = DIG_W'(disp.seconds % 6'd10);
    digit    = DIG_BLANK;
    colon_d  = 1'b1;

    if (disp.mode) begin
      colon_d = blink_c;
      case (scan_q)
        2'd3:    digit = min_ok ? min_tens : DIG_DASH;
        2'd2:    digit = min_ok ? min_ones : DIG_DASH;
        2'd1:    digit = sec_ok ? sec_tens : DIG_DASH;
        default: digit = sec_ok ? sec_ones : DIG_DASH;
      endcase
    end else begin
      case (scan_q)
        2'd3:    digit = DIG_W'(disp.capacity);
        2'd0:    digit = (disp.capacity == 3'd0) ? DIG_DASH
                                                 : DIG_W'(disp.empty_slot);
        default: digit = DIG_BLANK;
      endcase
    end

    seg_d   = seg_of(digit);
    anode_d = ~(4'b0001 << scan_q);
    scan_d  = scan_q + IDX_W'(1);
  end

  always_ff @(posedge clk_500Hz) begin
    if (reset) begin
      scan_q  <= '0;
      seg_q   <= '1;
      anode_q <= '1;
      colon_q <= 1'b1;
    end else begin
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
      colon_q <= colon_d;
    end
  end

  assign disp.seg   = seg_q;
  assign disp.anode = anode_q;
  assign disp.colon = colon_q;

endmodule

// File: tb/tb_multiplexed_display.sv
// Bench for multiplexed_display: directed vector table, reset/mode corners,
// and random inputs against a per-edge reference model.
module tb_multiplexed_display;

  logic clk_500Hz = 1'b0;
  logic reset     = 1'b1;

  multiplexed_display_if dif ();

  multiplexed_display dut (
    .clk_500Hz (clk_500Hz),
    .reset     (reset),
    .disp      (dif.slave)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  int errors = 0;
  int checks = 0;
  int exp_idx = 0;
  int since_rst = 0;

  logic [6:0] seg_tab [0:11];

  typedef struct {
    logic       mode;
    logic [2:0] capacity;
    logic [1:0] empty_slot;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] dig [0:3];
    logic       colon;
  } vec_t;

  vec_t vecs [0:9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected segment pattern for display position pos, from the view rules
  function automatic logic [6:0] model_seg(input logic m, input int cap,
      input int slot, input int mi, input int se, input int pos);
    int d;
    if (m) begin
      case (pos)
        3: d = (mi > 59) ? 11 : mi / 10;
        2: d = (mi > 59) ? 11 : mi % 10;
        1: d = (se > 59) ? 11 : se / 10;
        default: d = (se > 59) ? 11 : se % 10;
      endcase
    end else begin
      if (pos == 3)      d = cap;
      else if (pos == 0) d = (cap == 0) ? 11 : slot;
      else               d = 10;
    end
    return seg_tab[d];
  endfunction

  function automatic logic model_colon(input logic m, input int n);
`ifdef COLON_BLINK_EN
    return m ? logic'(((n - 1) / 250) % 2) : 1'b1;
`else
    return m ? 1'b0 : 1'b1;
`endif
  endfunction

  // One clock edge: capture applied inputs, sample after the edge, compare
  task automatic edge_check();
    logic r, m;
    int cap, slot, mi, se;
    logic [3:0] ea;
    r = reset; m = dif.mode; cap = int'(dif.capacity); slot = int'(dif.empty_slot);
    mi = int'(dif.minutes); se = int'(dif.seconds);
    @(posedge clk_500Hz);
    #1;
    if (r) begin
      chk("rst_anode", int'(dif.anode), 'hf);
      chk("rst_seg", int'(dif.seg), 'h7f);
      chk("rst_colon", int'(dif.colon), 1);
      exp_idx = 0;
      since_rst = 0;
    end else begin
      since_rst++;
      ea = ~(4'b0001 << exp_idx);
      chk("anode", int'(dif.anode), int'(ea));
      chk("seg", int'(dif.seg), int'(model_seg(m, cap, slot, mi, se, exp_idx)));
      chk("colon", int'(dif.colon), int'(model_colon(m, since_rst)));
      exp_idx = (exp_idx + 1) % 4;
    end
  endtask

  task automatic apply(input logic m, input int cap, input int slot,
                       input int mi, input int se);
    dif.mode       = m;
    dif.capacity   = 3'(cap);
    dif.empty_slot = 2'(slot);
    dif.minutes    = 6'(mi);
    dif.seconds    = 6'(se);
  endtask

  function automatic vec_t mk(input logic m, input int cap, input int slot,
      input int mi, input int se, input logic [6:0] d3, input logic [6:0] d2,
      input logic [6:0] d1, input logic [6:0] d0, input logic c);
    vec_t v;
    v.mode = m; v.capacity = 3'(cap); v.empty_slot = 2'(slot);
    v.minutes = 6'(mi); v.seconds = 6'(se);
    v.dig[3] = d3; v.dig[2] = d2; v.dig[1] = d1; v.dig[0] = d0;
    v.colon = c;
    return v;
  endfunction

  initial begin
    logic [3:0] seq [0:4];
    int pos;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9] = 7'b0010000; seg_tab[10] = 7'b1111111; seg_tab[11] = 7'b0111111;

    vecs[0] = mk(0, 2, 1, 0, 0,  7'b0100100, 7'b1111111, 7'b1111111, 7'b1111001, 1);
    vecs[1] = mk(0, 4, 0, 0, 0,  7'b0011001, 7'b1111111, 7'b1111111, 7'b1000000, 1);
    vecs[2] = mk(0, 0, 3, 0, 0,  7'b1000000, 7'b1111111, 7'b1111111, 7'b0111111, 1);
    vecs[3] = mk(1, 0, 0, 5, 3,  7'b1000000, 7'b0010010, 7'b1000000, 7'b0110000, 0);
    vecs[4] = mk(1, 0, 0, 15, 59, 7'b1111001, 7'b0010010, 7'b0010010, 7'b0010000, 0);
    vecs[5] = mk(1, 0, 0, 60, 59, 7'b0111111, 7'b0111111, 7'b0010010, 7'b0010000, 0);
    vecs[6] = mk(1, 0, 0, 7, 63, 7'b1000000, 7'b1111000, 7'b0111111, 7'b0111111, 0);
    vecs[7] = mk(0, 7, 2, 0, 0,  7'b1111000, 7'b1111111, 7'b1111111, 7'b0100100, 1);
    vecs[8] = mk(1, 0, 0, 59, 0, 7'b0010010, 7'b0010000, 7'b1000000, 7'b1000000, 0);
    vecs[9] = mk(1, 0, 0, 38, 46, 7'b0110000, 7'b0000000, 7'b0011001, 7'b0000010, 0);

    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;

    apply(0, 2, 1, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) edge_check();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_check();
      chk("scan_order", int'(dif.anode), int'(seq[i]));
    end

    // Directed table: each vector held for one full refresh
    for (int v = 0; v < 10; v++) begin
      apply(vecs[v].mode, int'(vecs[v].capacity), int'(vecs[v].empty_slot),
            int'(vecs[v].minutes), int'(vecs[v].seconds));
      for (int k = 0; k < 4; k++) begin
        edge_check();
        pos = 0;
        for (int b = 0; b < 4; b++) if (dif.anode[b] == 1'b0) pos = b;
        chk($sformatf("vec%0d_dig%0d", v, pos), int'(dif.seg), int'(vecs[v].dig[pos]));
        chk($sformatf("vec%0d_colon", v), int'(dif.colon), int'(vecs[v].colon));
      end
    end

    // Mode 1 -> 0 mid-scan: next digit and colon switch on that same edge
    apply(1, 3, 2, 12, 34);
    edge_check();
    edge_check();
    apply(0, 3, 2, 12, 34);
    edge_check();
    chk("mode_switch_colon", int'(dif.colon), 1);

    // Reset mid-scan: blank now, digit 0 on the following edge
    edge_check();
    reset = 1'b1;
    edge_check();
    reset = 1'b0;
    edge_check();
    chk("midscan_rst_anode", int'(dif.anode), 'he);
    chk("midscan_rst_seg", int'(dif.seg), int'(seg_tab[2]));

    // Random inputs changing every edge, long enough to span several blink periods
    for (int n = 0; n < 700; n++) begin
      apply(logic'(($urandom_range(0, 3) != 0)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)));
      edge_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplexed_display.md
Name: multiplexed_display

Overview:
- Four-digit, time-multiplexed 7-segment driver for the parking controller front panel.
- Mode 0 shows free capacity and the first empty slot number; mode 1 shows elapsed parking time as MM:SS with the colon lit.
- Scans one digit per clock of the 500 Hz display clock, giving a 125 Hz full refresh.
- All outputs are registered.

Parameters:
- None. Digit count (4), encodings and polarities are fixed.

Ports:
- clk_500Hz  input  1  display scan clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears scan state and blanks outputs
- mode  input  1  0 = capacity/slot view, 1 = time view
- capacity  input  3  free slots, unsigned binary 0..7
- empty_slot  input  2  index of first empty slot, 0..3
- minutes  input  6  elapsed minutes, unsigned binary 0..63
- seconds  input  6  elapsed seconds, unsigned binary 0..63
- seg  output  7  segment pattern, active-low, seg[0]=a … seg[6]=g
- anode  output  4  digit enables, active-low; anode[0] = rightmost digit
- colon  output  1  colon enable, active-low

Behaviour:
- Reset (sampled on clk_500Hz rising edge while reset=1):
  - scan index := 0
  - anode := 4'b1111
  - seg := 7'b1111111
  - colon := 1
- Scan sequence, each non-reset edge:
  - Outputs are loaded for the digit selected by the current scan index.
  - Index then advances 0→1→2→3→0 with wrap.
  - Exactly one anode bit is low: index i drives anode = ~(1<<i).
- The first edge after reset deasserts shows digit 0 (anode=1110).
- Inputs are sampled combinationally at each edge. An input or mode change is reflected on the next digit emitted, i.e. 1-cycle latency, with no glitch on other digits.
- Segment codes, gfedcba active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- Mode 0 digit mapping:
  - digit3 = capacity (decimal 0..7)
  - digit2 = blank
  - digit1 = blank
  - digit0 = empty_slot (0..3)
  - colon = 1 (off)
  - If capacity==0 (lot full): digit0 = dash, regardless of empty_slot.
- Mode 1 digit mapping:
  - digit3 = minutes/10
  - digit2 = minutes%10
  - digit1 = seconds/10
  - digit0 = seconds%10
  - colon = 0 (lit) on every scan cycle.
- Range and arithmetic rules (mode 1):
  - Binary-to-BCD conversion is combinational, valid for 0..59.
  - minutes>59: both minute digits show dash.
  - seconds>59: both seconds digits show dash.
  - Leading zeros are displayed, e.g. 00:00.
- Reset mid-scan: outputs blank on that edge; the scan restarts at digit 0 on the following edge.
- The scan index is not affected by mode changes.

Optional Feature:
- Macro COLON_BLINK_EN.
- Defined:
  - An internal 8-bit counter (reset to 0) counts clk_500Hz edges 0..249 then wraps, toggling a blink flag (reset 0 = lit) at each wrap.
  - In mode 1, colon = blink flag, giving 1 Hz (0.5 s lit / 0.5 s off).
  - In mode 0, colon stays 1.
  - The blink counter keeps running in mode 0.
- Undefined: no blink counter; colon = 0 steady in mode 1.

Test Plan:
- Reset held 3 edges, then released: during reset anode=1111, seg=1111111, colon=1. First post-reset edge gives anode=1110; the next edges give 1101, 1011, 0111, 1110.
- Mode 0, capacity=2, empty_slot=1:
  - anode=1110 → seg=1111001
  - anode=0111 → seg=0100100
  - anode=1101 and 1011 → blank
  - colon=1
- Mode 0, capacity=4, empty_slot=0 → digit3=0011001, digit0=1000000. Then capacity=0 → digit3=1000000, digit0=0111111 (dash).
- Mode 1, minutes=5, seconds=3:
  - digits 3..0 = 1000000, 0010010, 1000000, 0110000
  - colon=0 (without COLON_BLINK_EN)
- Mode 1, minutes=15, seconds=59 → digits 1,5,5,9. Then minutes=60 → digits 3 and 2 = dash, seconds digits still 5,9.
- Switch mode 1→0 mid-scan: the next emitted digit uses mode-0 mapping and colon returns to 1 on that same edge. With COLON_BLINK_EN, in mode 1, colon toggles exactly every 250 edges.
